// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: field widths, set-sequencer states
// and the month-length rule used by both the sequencer and the core's date wrap.
package clock_pkg;

    localparam int MONTH_W = 4;
    localparam int DATE_W  = 5;
    localparam int HRS_W   = 5;
    localparam int MIN_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        M_ADV,
        M_WAIT,
        R_ADV,
        R_WAIT,
        SETTLE,
        DONE
    } set_state_t;

    // No leap years: February is always 28 days.
    function automatic logic [DATE_W-1:0] days_in_month(input logic [MONTH_W-1:0] month);
        case (month)
            4'd2:                    days_in_month = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_sequencer_month_len.sv
// Combinational month length lookup used to validate a requested date.
module month_len
    import clock_pkg::*;
(
    input  logic [MONTH_W-1:0] month_i,
    output logic [DATE_W-1:0]  days_o
);

    assign days_o = days_in_month(month_i);

endmodule

// File: rtl/clock_set_sequencer.sv
// Drives the clock core's manual-set lines until Cur_* equals a latched target,
// month first, then date/hours/minutes concurrently; Error on bad target or timeout.
module clock_set_sequencer
    import clock_pkg::*;
#(
    parameter int MAX_STEPS = 64
)
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [MONTH_W-1:0] Tgt_month,
    input  logic [DATE_W-1:0]  Tgt_date,
    input  logic [HRS_W-1:0]   Tgt_hrs,
    input  logic [MIN_W-1:0]   Tgt_mins,
    input  logic [MONTH_W-1:0] Cur_month,
    input  logic [DATE_W-1:0]  Cur_date,
    input  logic [HRS_W-1:0]   Cur_hrs,
    input  logic [MIN_W-1:0]   Cur_mins,
    output logic               Timeset,
    output logic               MonthAdv,
    output logic               DateAdv,
    output logic               Hrsadv,
    output logic               Minadv,
    output logic               Busy,
    output logic               Done,
    output logic               Error
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);

    set_state_t         state_q;
    logic [MONTH_W-1:0] tgt_month_q;
    logic [DATE_W-1:0]  tgt_date_q;
    logic [HRS_W-1:0]   tgt_hrs_q;
    logic [MIN_W-1:0]   tgt_mins_q;
    logic [CNT_W-1:0]   step_q;
    logic               timeset_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic [DATE_W-1:0]  tgt_days;
    logic               target_ok;
    logic               month_ne;
    logic               date_ne;
    logic               hrs_ne;
    logic               mins_ne;
    logic               rest_ne;
    logic               step_max;

    month_len u_month_len (
        .month_i (tgt_month_q),
        .days_o  (tgt_days)
    );

    assign target_ok = (tgt_month_q >= 4'd1) && (tgt_month_q <= 4'd12) &&
                       (tgt_date_q >= 5'd1) && (tgt_date_q <= tgt_days) &&
                       (tgt_hrs_q <= 5'd23) && (tgt_mins_q <= 6'd59);

    assign month_ne = (Cur_month != tgt_month_q);
    assign date_ne  = (Cur_date  != tgt_date_q);
    assign hrs_ne   = (Cur_hrs   != tgt_hrs_q);
    assign mins_ne  = (Cur_mins  != tgt_mins_q);
    assign rest_ne  = date_ne || hrs_ne || mins_ne;
    assign step_max = (step_q == CNT_W'(MAX_STEPS));

    // Advance lines are decoded from the ADV state so the increment lands in
    // that cycle and is already visible on Cur_* during the following WAIT.
    assign MonthAdv = (state_q == M_ADV) && month_ne && !step_max;
    assign DateAdv  = (state_q == R_ADV) && date_ne  && !step_max;
    assign Hrsadv   = (state_q == R_ADV) && hrs_ne   && !step_max;
    assign Minadv   = (state_q == R_ADV) && mins_ne  && !step_max;

    assign Timeset = timeset_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Error   = error_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            tgt_month_q <= '0;
            tgt_date_q  <= '0;
            tgt_hrs_q   <= '0;
            tgt_mins_q  <= '0;
            step_q      <= '0;
            timeset_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        tgt_month_q <= Tgt_month;
                        tgt_date_q  <= Tgt_date;
                        tgt_hrs_q   <= Tgt_hrs;
                        tgt_mins_q  <= Tgt_mins;
                        error_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    step_q <= '0;
                    if (target_ok) begin
                        timeset_q <= 1'b1;
                        state_q   <= M_ADV;
                    end else begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                M_ADV: begin
                    if (!month_ne) begin
                        step_q  <= '0;
                        state_q <= R_ADV;
                    end else if (step_max) begin
                        error_q   <= 1'b1;
                        timeset_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        step_q  <= step_q + CNT_W'(1);
                        state_q <= M_WAIT;
                    end
                end
                M_WAIT: state_q <= M_ADV;
                R_ADV: begin
                    if (!rest_ne) begin
                        state_q <= SETTLE;
                    end else if (step_max) begin
                        error_q   <= 1'b1;
                        timeset_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        step_q  <= step_q + CNT_W'(1);
                        state_q <= R_WAIT;
                    end
                end
                R_WAIT: state_q <= R_ADV;
                SETTLE: begin
                    timeset_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
